// File: rtl/matrix_scan_controller.sv
// Purpose : scans a 5x7 LED matrix one column at a time, with an optional alert blink.
// Latency : outputs are registered; the first column drives 1 clock after reset releases.
// Backpr. : none; scanning is free-running and the inputs are sampled once per frame.
//
// Ports:
//   i_clock        system clock (rising edge)
//   i_reset        synchronous active-high reset
//   i_col_2        image rows for physical columns 0 and 4 (bit 6 = top row)
//   i_col_1        image rows for physical columns 1 and 3
//   i_col_0        image rows for physical column 2
//   i_alert        level request to blink the displayed image
//   o_col_select   active-low one-hot column enable, bit n = physical column n
//   o_row_data     active-high row drive for the enabled column
//   o_frame_done   one-clock pulse in the guard slot that ends a 5-column frame
//
// Build option: define MATRIX_BLINK_EN to compile in the alert blink logic.
// Without it the image is never blanked and i_alert is ignored.

module matrix_scan_controller #(
    parameter int SCAN_DIV     = 1000,  // clocks per column slot (1 guard + SCAN_DIV-1 drive), 2..65535
    parameter int BLINK_FRAMES = 25     // frames per blink half-period, 1..255
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [6:0] i_col_2,
    input  logic [6:0] i_col_1,
    input  logic [6:0] i_col_0,
    input  logic       i_alert,
    output logic [4:0] o_col_select,
    output logic [6:0] o_row_data,
    output logic       o_frame_done
);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [15:0] r_pre;
    logic [15:0] w_pre_nxt;
    logic [6:0]  r_sh2;
    logic [6:0]  r_sh1;
    logic [6:0]  r_sh0;
    logic [6:0]  w_sh2_nxt;
    logic [6:0]  w_sh1_nxt;
    logic [6:0]  w_sh0_nxt;
    logic        w_blank_nxt;
    logic [4:0]  w_col_select_nxt;
    logic [6:0]  w_row_data_nxt;
    logic        w_frame_done_nxt;

    // Next-state logic. The prescaler is 0 throughout the guard clock and
    // counts 1..SCAN_DIV-1 across the drive clocks, so a slot is SCAN_DIV clocks.
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_pre_nxt        = r_pre;
        w_sh2_nxt        = r_sh2;
        w_sh1_nxt        = r_sh1;
        w_sh0_nxt        = r_sh0;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            ST_GUARD: begin
                w_state_nxt = ST_DRIVE;
                w_pre_nxt   = r_pre + 16'd1;
                // Latch the image only at the start of a frame so a frame
                // never mixes old and new input data.
                if (r_idx == 3'd0) begin
                    w_sh2_nxt = i_col_2;
                    w_sh1_nxt = i_col_1;
                    w_sh0_nxt = i_col_0;
                end
            end
            ST_DRIVE: begin
                if (r_pre == PRE_LAST) begin
                    w_state_nxt      = ST_GUARD;
                    w_pre_nxt        = 16'd0;
                    w_idx_nxt        = (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
                    w_frame_done_nxt = (r_idx == 3'd4);
                end else begin
                    w_pre_nxt = r_pre + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_GUARD;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next-state values
    // to line up with the state they describe.
    always_comb begin
        w_col_select_nxt = 5'b11111;
        w_row_data_nxt   = 7'd0;
        if (w_state_nxt == ST_DRIVE) begin
            w_col_select_nxt = ~(5'b00001 << w_idx_nxt);
            case (w_idx_nxt)
                3'd0, 3'd4: w_row_data_nxt = w_sh2_nxt;
                3'd1, 3'd3: w_row_data_nxt = w_sh1_nxt;
                default:    w_row_data_nxt = w_sh0_nxt;
            endcase
            if (w_blank_nxt) begin
                w_row_data_nxt = 7'd0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_GUARD;
            r_idx        <= 3'd0;
            r_pre        <= 16'd0;
            r_sh2        <= 7'd0;
            r_sh1        <= 7'd0;
            r_sh0        <= 7'd0;
            o_col_select <= 5'b11111;
            o_row_data   <= 7'd0;
            o_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_pre        <= w_pre_nxt;
            r_sh2        <= w_sh2_nxt;
            r_sh1        <= w_sh1_nxt;
            r_sh0        <= w_sh0_nxt;
            o_col_select <= w_col_select_nxt;
            o_row_data   <= w_row_data_nxt;
            o_frame_done <= w_frame_done_nxt;
        end
    end

`ifdef MATRIX_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] r_fcnt;
    logic [7:0] w_fcnt_nxt;
    logic       r_blank;

    // Frames are counted on the frame_done guard clock; dropping alert
    // clears the blink state at once so the image reappears immediately.
    always_comb begin
        w_fcnt_nxt  = r_fcnt;
        w_blank_nxt = r_blank;
        if (!i_alert) begin
            w_fcnt_nxt  = 8'd0;
            w_blank_nxt = 1'b0;
        end else if (o_frame_done) begin
            if (r_fcnt == BLINK_LAST) begin
                w_fcnt_nxt  = 8'd0;
                w_blank_nxt = ~r_blank;
            end else begin
                w_fcnt_nxt = r_fcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fcnt  <= 8'd0;
            r_blank <= 1'b0;
        end else begin
            r_fcnt  <= w_fcnt_nxt;
            r_blank <= w_blank_nxt;
        end
    end
`else
    // Blink logic is absent: alert and the blink period have no effect.
    logic [8:0] w_unused_blink_cfg;
    assign w_unused_blink_cfg = {i_alert, 8'(BLINK_FRAMES)};
    assign w_blank_nxt        = 1'b0;
`endif

endmodule

// File: doc/matrix_scan_controller.md
MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clocks per column slot (1 guard + SCAN_DIV-1 drive), legal range 2..65535.
REQ-002 Parameter BLINK_FRAMES, default 25: frames per blink half-period, legal range 1..255.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 col_2  input  7  image rows for physical columns 0 and 4 (bit 6 = top row).
REQ-006 col_1  input  7  image rows for physical columns 1 and 3.
REQ-007 col_0  input  7  image rows for physical column 2.
REQ-008 alert  input  1  level request to blink the displayed image.
REQ-009 col_select  output  5  active-low one-hot column enable; bit n = physical column n.
REQ-010 row_data  output  7  active-high row drive for the enabled column.
REQ-011 frame_done  output  1  one-clock pulse marking the end of a 5-column frame.

Function
REQ-012 FSM has two states: GUARD (all columns off) and DRIVE (one column on); all outputs are registered.
REQ-013 Column index runs 0,1,2,3,4 and wraps 4->0; it advances on every DRIVE->GUARD transition.
REQ-014 Prescaler clears to 0 in the GUARD cycle and increments once per clock in DRIVE.
REQ-015 GUARD lasts exactly one clock and then goes to DRIVE; DRIVE goes to GUARD on the clock where the prescaler equals SCAN_DIV-1.
REQ-016 Each column slot is therefore SCAN_DIV clocks (1 GUARD + SCAN_DIV-1 DRIVE), and a frame is 5*SCAN_DIV clocks.
REQ-017 In GUARD: col_select = 5'b11111 and row_data = 0.
REQ-018 In DRIVE: col_select = ~(1<<index); row_data = shadow col_2 for index 0/4, shadow col_1 for index 1/3, shadow col_0 for index 2, forced to 0 when blank_phase = 1.
REQ-019 Shadow registers load col_2/col_1/col_0 only in a GUARD cycle with index 0. Input changes at any other time take effect at the next frame start; no tearing within a frame.
REQ-020 frame_done = 1 for exactly the GUARD cycle following DRIVE of column 4, and 0 otherwise.
REQ-021 Blink: while alert = 1, a frame counter increments at each frame_done. When it reaches BLINK_FRAMES-1 at frame_done, it clears and blank_phase toggles.
REQ-022 When alert = 0, the frame counter and blank_phase clear on the next clock, so the image is visible from the following DRIVE cycle.
REQ-023 Scanning never stops: alert and blank_phase affect only row_data, never col_select or timing.

Reset
REQ-024 Reset, asserted in any state including mid-DRIVE, sets on the next edge: state = GUARD, index = 0, prescaler = 0, shadows = 0, frame counter = 0, blank_phase = 0.
REQ-025 Outputs on the edge reset is sampled: col_select = 5'b11111, row_data = 0, frame_done = 0.
REQ-026 The first post-reset GUARD cycle loads the shadows, so the first frame shows the current inputs.

Configuration
REQ-027 Macro MATRIX_BLINK_EN defined: blink logic per REQ-021..022 is compiled in.
REQ-028 Macro MATRIX_BLINK_EN undefined: frame counter and blank_phase are absent, blank_phase is constant 0, and alert is ignored; all other behaviour is identical.

Verification (SCAN_DIV=4, BLINK_FRAMES=2, MATRIX_BLINK_EN defined unless stated)
REQ-029 Bench covers the reset check: hold reset 3 clocks -> col_select = 11111, row_data = 00, frame_done = 0; the first DRIVE occurs 1 clock after reset release.
REQ-030 Bench covers the scan order: col_2 = 7'h49, col_1 = 7'h2A, col_0 = 7'h7F.
- Expected DRIVE sequence: col_select 11110/11101/11011/10111/01111 with row_data 49/2A/7F/2A/49.
- Each column: 3 DRIVE clocks + 1 GUARD clock (all off).
- frame_done pulses every 20 clocks.
REQ-031 Bench covers a mid-frame change: change col_0 to 7'h00 while column 1 is driven -> column 2 still shows 7F in that frame, then 00 in the next frame.
REQ-032 Bench covers blinking: alert = 1 from frame start -> frames 1-2 show the image, frames 3-4 row_data = 0 with columns still scanning, frame 5 shows the image; deasserting alert during frame 3 -> image visible from the next DRIVE cycle.
REQ-033 Bench covers reset mid-operation: assert reset during DRIVE of column 3 for 1 clock -> all columns off, then the scan restarts at column 0 with the freshly loaded shadows.
REQ-034 Bench covers the macro-off build (MATRIX_BLINK_EN undefined): alert = 1 for 10 frames -> row_data never blanks.
